// File: rtl/rv_mem_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the unified memory port.
// The arbiter uses the slave view; the environment (core plus memory) uses the master view.
interface rv_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction fetch port
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            i_err;
    // Data access port
    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            d_err;
    // Unified memory port
    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    // Status
    logic            busy;
    logic            stray_rsp;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy, stray_rsp
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy, stray_rsp
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D), one transaction
// in flight. D has fixed priority; a starvation counter and a response timeout bound latency.
module rv_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input logic             clk,
    input logic             rst_n,
    rv_mem_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          req_we;
    logic [BW-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          stray_q;

    logic waiting, tmo_hit, rsp_fire, d_wins, i_fire, d_fire;

    assign waiting  = (state == WAIT_I) || (state == WAIT_D);
    assign tmo_hit  = waiting && (tmo_cnt == TMO_LAST);
    assign rsp_fire = waiting && (bus.mem_rvalid || tmo_hit);
    assign d_wins   = bus.d_req && !(bus.i_req && (starve_cnt == STARVE_MAX));
    assign i_fire   = rsp_fire && (state == WAIT_I);
    assign d_fire   = rsp_fire && (state == WAIT_D);

    assign bus.mem_req   = (state == ISSUE_I) || (state == ISSUE_D);
    assign bus.mem_we    = req_we;
    assign bus.mem_be    = req_be;
    assign bus.mem_addr  = req_addr;
    assign bus.mem_wdata = req_wdata;
    assign bus.busy      = (state != IDLE);
    assign bus.stray_rsp = stray_q;

    assign bus.i_gnt    = (state == ISSUE_I) && bus.mem_gnt;
    assign bus.d_gnt    = (state == ISSUE_D) && bus.mem_gnt;
    assign bus.i_rvalid = i_fire;
    assign bus.d_rvalid = d_fire;
    // A real response on the timeout cycle wins, so err needs mem_rvalid low.
    assign bus.i_err    = i_fire && !bus.mem_rvalid;
    assign bus.d_err    = d_fire && !bus.mem_rvalid;
    assign bus.i_rdata  = (i_fire && bus.mem_rvalid) ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (d_fire && bus.mem_rvalid) ? bus.mem_rdata : '0;

    // NOTE: all state lives in this one block with non-blocking assignments, so every
    // register sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            // NOTE: the payload registers drive mem_* directly, so they are reset as well.
            req_we     <= 1'b0;
            req_be     <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            stray_q    <= 1'b0;
        end else begin
            // Registered so the pulse is clean and cannot leak through reset.
            stray_q <= bus.mem_rvalid && !waiting;
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state     <= ISSUE_D;
                        req_we    <= bus.d_we;
                        req_be    <= bus.d_be;
                        req_addr  <= bus.d_addr;
                        req_wdata <= bus.d_wdata;
                        if (!bus.i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (bus.i_req) begin
                        state      <= ISSUE_I;
                        req_we     <= 1'b0;
                        req_be     <= '1;
                        req_addr   <= bus.i_addr;
                        req_wdata  <= '0;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ISSUE_I, ISSUE_D: begin
                    if (bus.mem_gnt) begin
                        state   <= (state == ISSUE_I) ? WAIT_I : WAIT_D;
                        tmo_cnt <= '0;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (rsp_fire) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Arbitrates the core's single unified memory port between instruction fetch (IF, port I) and data access (MA, port D).
- One outstanding transaction at a time.
- Data has fixed priority; a starvation counter bounds fetch delay.
- A response timeout guarantees forward progress.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive D-wins while I is also waiting before I is forced to win (>=1)
TIMEOUT, 64, WAIT cycles without mem_rvalid before an error response (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_gnt
i_addr  in  AW  fetch address
i_gnt  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch response valid (1-cycle pulse)
i_rdata  out  DW  fetch response data
i_err  out  1  qualifies i_rvalid: timeout
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=store, 0=load
d_be  in  DW/8  byte enables
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted (pulse)
d_rvalid  out  1  data response/ack valid (pulse)
d_rdata  out  DW  load data
d_err  out  1  qualifies d_rvalid: timeout
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DW/8  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response (also returned for writes)
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE
stray_rsp  out  1  pulse: mem_rvalid received outside WAIT_x; dropped

Behaviour:
- States: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D. Reset -> IDLE. Reset clears all registers; every output is 0 during and after reset. Any in-flight transaction is abandoned.
- IDLE, arbitration:
  - If d_req and not (i_req and starve_cnt==STARVE_LIMIT): go ISSUE_D.
  - Else if i_req: go ISSUE_I.
  - The winner's payload is latched into the request register on the transition. I payload: we=0, be=all ones, wdata=0.
- starve_cnt, updated only on IDLE decisions:
  - +1 when both requests are pending and D wins.
  - Cleared when I wins, or when i_req is low.
  - Saturates at STARVE_LIMIT.
- ISSUE_x:
  - mem_req=1; mem_* driven from latched registers, stable until accepted.
  - On mem_gnt: x_gnt=1 that cycle, go WAIT_x, timeout counter cleared.
  - Request-side inputs are ignored in this state. A requester dropping req does not cancel the transaction.
- WAIT_x:
  - mem_req=0.
  - On mem_rvalid: x_rvalid=1, x_rdata=mem_rdata, x_err=0, go IDLE.
  - Else counter+1. When the counter reaches TIMEOUT-1 without mem_rvalid: x_rvalid=1, x_err=1, x_rdata=0, go IDLE.
  - mem_rvalid and timeout in the same cycle: the response wins, err=0.
- Arbitration latency: a request seen in IDLE gives mem_req the next cycle. Minimum transaction: IDLE -> ISSUE (gnt same cycle) -> WAIT (rvalid same cycle) -> IDLE, i.e. 3 cycles per access. IDLE re-arbitrates with no bubble beyond this.
- mem_gnt or mem_rvalid arriving outside its valid state is ignored. mem_rvalid in IDLE or ISSUE_x additionally pulses stray_rsp.
- rdata outputs: 0 whenever the matching rvalid is 0. i_* and d_* responses are never asserted in the same cycle.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, mem_gnt tied 1, mem_rvalid 2 cycles after gnt with 0x00500093 -> mem_req high 1 cycle with addr 0x100, we=0, be=0xF; i_gnt pulse; i_rvalid=1, i_rdata=0x00500093, i_err=0; busy back to 0.
- Simultaneous: i_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF, be 0x3) in the same cycle -> D issued first with mem_we=1, be=0x3; I issued only after d_rvalid.
- Starvation: d_req held permanently, i_req held, STARVE_LIMIT=4 -> exactly 4 D transactions, then I granted; starve_cnt back to 0.
- Memory backpressure: mem_gnt low 5 cycles in ISSUE_D while d_addr changes on the inputs -> mem_addr stays at the latched value; d_gnt only on the cycle mem_gnt=1.
- Timeout: TIMEOUT=64, mem_rvalid never returns for a fetch -> i_rvalid=1, i_err=1, i_rdata=0 exactly 64 cycles after the grant cycle. A later mem_rvalid in IDLE -> stray_rsp pulse, no i_rvalid.
- Reset mid-WAIT_D: rst_n low -> all outputs 0 immediately. After release: IDLE, busy=0, the pending response is never delivered.
